// File: rtl/sw_debounce.sv
// Slide-switch debouncer for an 8-bit switch bank.
// The raw switches are synchronised and then sampled on a slow prescaler tick.
// A new value is accepted only after it has been seen on STABLE_TICKS
// consecutive ticks following the tick that captured it. The accepted byte
// drives two 4-bit operands. A one-cycle pulse marks every real change.
module sw_debounce #(
  parameter int DIV_BITS     = 17,
  parameter int STABLE_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] sw_raw,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       changed,
  output logic       settled
);

  localparam logic [0:0] STABLE   = 1'b0;
  localparam logic [0:0] SETTLING = 1'b1;

  // The final candidate count. Reaching it on a matching tick means the
  // candidate has been seen on STABLE_TICKS further ticks after its capture.
  localparam logic [3:0] LAST_CNT = 4'(STABLE_TICKS - 1);

  logic [7:0]          sync1_reg;
  logic [7:0]          sync2_reg;
  logic [DIV_BITS-1:0] presc_reg;
  logic                tick;

  logic [0:0] state_reg, state_next;
  logic [7:0] cand_reg,  cand_next;
  logic [3:0] cnt_reg,   cnt_next;
  logic [7:0] acc_reg,   acc_next;
  logic       changed_reg, changed_next;

  // Two-flop synchroniser. sync2 is the only copy of the switches used later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 8'h00;
      sync2_reg <= 8'h00;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Free-running prescaler. It wraps naturally at 2^DIV_BITS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Tick is asserted in the last cycle of each prescaler period.
  assign tick = &presc_reg;

  // Next-state logic. Nothing moves except on a tick.
  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    changed_next = 1'b0;
    if (tick) begin
      case (state_reg)
        STABLE: begin
          if (sync2_reg != cand_reg) begin
            cand_next  = sync2_reg;
            cnt_next   = 4'd0;
            state_next = SETTLING;
          end
        end
        SETTLING: begin
          if (sync2_reg != cand_reg) begin
            // The switches bounced, so restart the count on the new sample.
            cand_next = sync2_reg;
            cnt_next  = 4'd0;
          end else if (cnt_reg == LAST_CNT) begin
            // Accept the candidate. Pulse only when the value really differs,
            // so a switch that bounced back to the old value stays silent.
            acc_next     = cand_reg;
            changed_next = (cand_reg != acc_reg);
            state_next   = STABLE;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        default: begin
          state_next = STABLE;
        end
      endcase
    end
  end

  // State and datapath registers. changed is registered with acc, so the
  // pulse and the new operands appear in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= STABLE;
      cand_reg    <= 8'h00;
      cnt_reg     <= 4'd0;
      acc_reg     <= 8'h00;
      changed_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      changed_reg <= changed_next;
    end
  end

  assign a_out   = acc_reg[3:0];
  assign b_out   = acc_reg[7:4];
  assign changed = changed_reg;
  assign settled = (state_reg == STABLE);

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter DIV_BITS, default 17: sample-tick prescaler width; one tick every 2^DIV_BITS clocks.
REQ-002 Parameter STABLE_TICKS, default 4, legal range 2..15: consecutive equal samples required to accept a new switch value.
REQ-003 Port clock  input  1  board clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port sw_raw  input  8  raw, unsynchronised, bouncing slide-switch bank.
REQ-006 Port a_out  output  4  debounced operand A, equal to the accepted value bits [3:0].
REQ-007 Port b_out  output  4  debounced operand B, equal to the accepted value bits [7:4].
REQ-008 Port changed  output  1  one-clock pulse, asserted in the same cycle that a_out or b_out first shows a new value.
REQ-009 Port settled  output  1  high when the FSM is in STABLE.

Function
REQ-010 The block SHALL pass sw_raw through a two-flop synchroniser (sync1, sync2) before any use; sync2 is the sampled value.
REQ-011 Prescaler: the block SHALL count 0..2^DIV_BITS-1 and wrap to 0; tick is high for the one cycle in which the count equals 2^DIV_BITS-1.
REQ-012 Registers: cand[7:0] holds the candidate value, cnt[3:0] is the stability counter, acc[7:0] is the accepted value; a_out = acc[3:0] and b_out = acc[7:4].
REQ-013 FSM states SHALL be STABLE and SETTLING; all transitions occur only on tick cycles, and every register holds in non-tick cycles.
REQ-014 STABLE with tick and sync2 != cand: cand <= sync2, cnt <= 0, next state SETTLING.
REQ-015 STABLE with tick and sync2 == cand: no register changes.
REQ-016 SETTLING with tick and sync2 != cand (bounce): cand <= sync2, cnt <= 0, remain in SETTLING.
REQ-017 SETTLING with tick, sync2 == cand, cnt < STABLE_TICKS-1: cnt <= cnt+1.
REQ-018 SETTLING with tick, sync2 == cand, cnt == STABLE_TICKS-1: acc <= cand, next state STABLE; changed SHALL be registered and high in the following cycle only if cand != acc.
REQ-019 A value that returns to the old acc before acceptance SHALL produce no changed pulse, and acc SHALL stay unchanged.
REQ-020 Acceptance latency SHALL be exactly STABLE_TICKS ticks after the tick that first captured the new value.
REQ-021 Activity on sw_raw that starts and ends between two ticks SHALL have no effect.
REQ-022 changed SHALL never be high for two consecutive cycles; changed and the a_out/b_out update SHALL appear in the same cycle.
REQ-023 settled SHALL be low throughout SETTLING, including the cycle in which the tick that starts SETTLING is registered.

Reset
REQ-024 While reset = 0, the block SHALL asynchronously clear sync1, sync2, prescaler, cand, cnt, acc and changed to 0, and set the state to STABLE.
REQ-025 During and immediately after reset: a_out = 0, b_out = 0, changed = 0, settled = 1.
REQ-026 Reset asserted mid-SETTLING SHALL abandon the candidate with no changed pulse.
REQ-027 Release of reset SHALL be synchronous in effect: the prescaler starts from 0 on the first rising edge with reset = 1.

Verification (DIV_BITS=2, STABLE_TICKS=3; tick every 4 clocks)
REQ-028 Reset, then sw_raw=8'h00 held -> a_out=0, b_out=0, settled=1, changed never pulses.
REQ-029 sw_raw steps cleanly 00 -> 8'h5A -> a_out=4'hA and b_out=4'h5 exactly 3 ticks after the capturing tick, with one changed pulse coincident with the update and settled returning to 1.
REQ-030 sw_raw toggles 00/5A on alternate ticks for 6 ticks, then holds 5A -> no update until 3 ticks of stability after the last toggle, followed by one changed pulse.
REQ-031 sw_raw 00 -> 8'h33 for 2 ticks, then back to 00 -> acc stays 0, no changed pulse, settled returns to 1.
REQ-032 A 2-clock glitch to 8'hFF placed entirely between ticks -> no state change, settled stays 1.
REQ-033 reset pulsed low mid-SETTLING toward 8'hC3 -> outputs go to 0 immediately, no changed pulse; with 8'hC3 still held after release, acceptance completes normally as a fresh capture.
